// File: rtl/cpu_ocimem_arbiter_if.sv
// cpu_ocimem_arbiter_if
//   Bundles every non-clock signal of the OCI RAM arbiter: the JTAG debug
//   slave strobes and monitor handshake, the Avalon-MM debug_mem slave port,
//   the single-port OCI RAM port, and two debug taps (FSM state and the
//   current JTAG word address).
//   Modports:
//     slave  - the arbiter itself
//     master - the surrounding logic (JTAG wrapper, Avalon master, RAM)
interface cpu_ocimem_arbiter_if #(
    parameter int ADDR_W = 8
);
    // JTAG side
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    // Avalon-MM side
    logic [ADDR_W-1:0] av_address;
    logic              av_read;
    logic              av_write;
    logic [31:0]       av_writedata;
    logic [3:0]        av_byteenable;
    logic              debugaccess;
    logic [31:0]       av_readdata;
    logic              av_waitrequest;
    // OCI RAM side
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    // Debug taps
    logic [2:0]        dbg_state;
    logic [ADDR_W-1:0] dbg_jtag_addr;

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        input  av_address, av_read, av_write, av_writedata, av_byteenable, debugaccess,
        input  ram_rdata,
        output MonDReg, monitor_ready, monitor_error,
        output av_readdata, av_waitrequest,
        output ram_addr, ram_wdata, ram_be, ram_we,
        output dbg_state, dbg_jtag_addr
    );

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        output av_address, av_read, av_write, av_writedata, av_byteenable, debugaccess,
        output ram_rdata,
        input  MonDReg, monitor_ready, monitor_error,
        input  av_readdata, av_waitrequest,
        input  ram_addr, ram_wdata, ram_be, ram_we,
        input  dbg_state, dbg_jtag_addr
    );
endinterface

// File: rtl/cpu_ocimem_arbiter.sv
// cpu_ocimem_arbiter
//   Shares the single-port OCI debug RAM between JTAG debug strobes and the
//   CPU-side Avalon-MM debug_mem port. JTAG reads return through MonDReg;
//   simultaneous requests are served round-robin.
//   Ports:
//     clk      - system clock, rising edge
//     reset_n  - asynchronous active-low reset
//     bus      - cpu_ocimem_arbiter_if.slave (JTAG, Avalon, RAM, debug taps)
//
//   Handshakes:
//     Avalon: av_read/av_write are held by the master; a transfer completes in
//       the single cycle where the request is high and av_waitrequest is low.
//       Writes acknowledge in A_WR (the RAM write happens that same cycle);
//       reads acknowledge in A_ACK with av_readdata valid. The cycle after an
//       acknowledge is IDLE, so a held request is never taken twice.
//     JTAG: strobes are single-cycle with no back-pressure. A strobe is only
//       accepted while monitor_ready is high; otherwise it is dropped and
//       monitor_error latches until the next take_action_ocimem_a.
module cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cpu_ocimem_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_J_WR    = 3'd1,
        S_J_RD    = 3'd2,
        S_J_RDCAP = 3'd3,
        S_A_WR    = 3'd4,
        S_A_RD    = 3'd5,
        S_A_RDCAP = 3'd6,
        S_A_ACK   = 3'd7
    } state_t;

    state_t            state;
    logic              jtag_pend;
    logic              jtag_op_wr;
    logic [31:0]       jtag_wdata;
    logic [ADDR_W-1:0] jtag_addr;
    logic              last_grant_j;
    logic              av_ack;
    logic [31:0]       mon_dreg;
    logic              mon_error;
    logic [31:0]       av_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic              ram_we;

    logic              strobe_any;
    logic              accept;
    logic              new_ram_op;
    logic              new_is_wr;
    logic [ADDR_W-1:0] addr_cur;
    logic              wr_cur;
    logic [31:0]       wdata_cur;
    logic              j_req;
    logic              a_req;
    logic              grant_j;
    logic              in_jtag_state;
    logic              unused_jdo_bits;

    // A freshly accepted strobe is visible to the IDLE decision in the same
    // cycle, so an uncontended JTAG RAM op starts on the very next cycle.
    always_comb begin
        strobe_any = bus.take_action_ocimem_a | bus.take_no_action_ocimem_a |
                     bus.take_action_ocimem_b;
        accept     = strobe_any & ~jtag_pend;
        new_ram_op = accept & (bus.take_action_ocimem_b | bus.take_no_action_ocimem_a |
                               (bus.take_action_ocimem_a & bus.jdo[34]));
        new_is_wr  = ~bus.take_action_ocimem_a & bus.take_action_ocimem_b;
        addr_cur   = (accept & bus.take_action_ocimem_a) ? bus.jdo[10 +: ADDR_W] : jtag_addr;
        wr_cur     = new_ram_op ? new_is_wr : jtag_op_wr;
        wdata_cur  = new_ram_op ? bus.jdo[34:3] : jtag_wdata;
        j_req      = jtag_pend | new_ram_op;
        a_req      = bus.av_read | bus.av_write;
        // On a tie the side that lost the previous tie wins.
        grant_j    = j_req & (~a_req | ~last_grant_j);
        in_jtag_state = (state == S_J_WR) | (state == S_J_RD) | (state == S_J_RDCAP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            jtag_pend    <= 1'b0;
            jtag_op_wr   <= 1'b0;
            jtag_wdata   <= '0;
            jtag_addr    <= '0;
            last_grant_j <= 1'b0;
            av_ack       <= 1'b0;
            mon_dreg     <= '0;
            mon_error    <= 1'b0;
            av_rdata     <= '0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_be       <= '0;
            ram_we       <= 1'b0;
        end else begin
            ram_we <= 1'b0;

            // JTAG capture. Busy is equivalent to jtag_pend, which stays set
            // through every J_* state.
            if (accept) begin
                if (bus.take_action_ocimem_a) begin
                    jtag_addr <= bus.jdo[10 +: ADDR_W];
                end
                if (new_ram_op) begin
                    jtag_pend  <= 1'b1;
                    jtag_op_wr <= new_is_wr;
                    jtag_wdata <= bus.jdo[34:3];
                end
            end

            if (bus.take_action_ocimem_a) begin
                mon_error <= 1'b0;
            end else if (strobe_any & jtag_pend) begin
                mon_error <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (j_req & a_req) begin
                        last_grant_j <= grant_j;
                    end
                    if (grant_j) begin
                        ram_addr <= addr_cur;
                        if (wr_cur) begin
                            ram_we    <= 1'b1;
                            ram_wdata <= wdata_cur;
                            ram_be    <= 4'hF;
                            state     <= S_J_WR;
                        end else begin
                            state <= S_J_RD;
                        end
                    end else if (a_req) begin
                        ram_addr <= bus.av_address;
                        if (bus.av_write) begin
                            // Writes without debugaccess are acknowledged
                            // but never reach the RAM.
                            ram_we    <= bus.debugaccess;
                            ram_wdata <= bus.av_writedata;
                            ram_be    <= bus.av_byteenable;
                            av_ack    <= 1'b1;
                            state     <= S_A_WR;
                        end else begin
                            state <= S_A_RD;
                        end
                    end
                end
                S_J_WR: begin
                    jtag_pend <= 1'b0;
                    jtag_addr <= jtag_addr + 1'b1;
                    state     <= S_IDLE;
                end
                S_J_RD: begin
                    state <= S_J_RDCAP;
                end
                S_J_RDCAP: begin
                    mon_dreg  <= bus.ram_rdata;
                    jtag_pend <= 1'b0;
                    jtag_addr <= jtag_addr + 1'b1;
                    state     <= S_IDLE;
                end
                S_A_WR: begin
                    av_ack <= 1'b0;
                    state  <= S_IDLE;
                end
                S_A_RD: begin
                    state <= S_A_RDCAP;
                end
                S_A_RDCAP: begin
                    av_rdata <= bus.ram_rdata;
                    av_ack   <= 1'b1;
                    state    <= S_A_ACK;
                end
                S_A_ACK: begin
                    av_ack <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.MonDReg        = mon_dreg;
    assign bus.monitor_ready  = ~jtag_pend & ~in_jtag_state;
    assign bus.monitor_error  = mon_error;
    assign bus.av_readdata    = av_rdata;
    assign bus.av_waitrequest = ~av_ack;
    assign bus.ram_addr       = ram_addr;
    assign bus.ram_wdata      = ram_wdata;
    assign bus.ram_be         = ram_be;
    assign bus.ram_we         = ram_we;
    assign bus.dbg_state      = state;
    assign bus.dbg_jtag_addr  = jtag_addr;

    // jdo carries fields for other debug registers; only [34:3] matter here.
    assign unused_jdo_bits = ^{bus.jdo[37:35], bus.jdo[2:0]};

endmodule

// File: tb/tb_cpu_ocimem_arbiter.sv
module tb_cpu_ocimem_arbiter;

  localparam int K_A  = 0;
  localparam int K_B  = 1;
  localparam int K_NA = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_J_RD    = 3'd2;
  localparam logic [2:0] ST_J_RDCAP = 3'd3;
  localparam logic [2:0] ST_A_RD    = 3'd5;

  logic clk;
  logic reset_n;
  logic mem_clear;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:255];

  cpu_ocimem_arbiter_if #(.ADDR_W(8)) bus ();

  cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- OCI RAM model: 1-cycle read latency, byte enables ----------------
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (bus.ram_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_be[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: expected queue empty, got 0x%0h", tag, got);
    end else begin
      e = exp_q.pop_front();
      check(tag, {32'h0, got}, {32'h0, e});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jtag_strobe(input int kind, input logic [7:0] addr, input logic rd,
                             input logic [31:0] data);
    logic [37:0] v;
    v = '0;
    case (kind)
      K_A:     begin v[17:10] = addr; v[34] = rd; bus.take_action_ocimem_a = 1'b1; end
      K_B:     begin v[34:3] = data; bus.take_action_ocimem_b = 1'b1; end
      default: bus.take_no_action_ocimem_a = 1'b1;
    endcase
    bus.jdo = v;
    step(1);
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.jdo = '0;
  endtask

  task automatic av_start(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic dbg);
    bus.av_write      = wr;
    bus.av_read       = ~wr;
    bus.av_address    = addr;
    bus.av_writedata  = data;
    bus.av_byteenable = be;
    bus.debugaccess   = dbg;
  endtask

  task automatic av_stop();
    bus.av_write = 1'b0;
    bus.av_read  = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    mem_clear = 1'b1;
    bus.jdo = '0;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.av_address = '0;
    bus.av_read = 1'b0;
    bus.av_write = 1'b0;
    bus.av_writedata = '0;
    bus.av_byteenable = '0;
    bus.debugaccess = 1'b0;
    step(3);
    mem_clear = 1'b0;

    // Reset values
    check("rst_mondreg", bus.MonDReg, 0);
    check("rst_av_readdata", bus.av_readdata, 0);
    check("rst_monitor_ready", bus.monitor_ready, 1);
    check("rst_monitor_error", bus.monitor_error, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_waitrequest", bus.av_waitrequest, 1);
    check("rst_jtag_addr", bus.dbg_jtag_addr, 0);
    check("rst_state", bus.dbg_state, ST_IDLE);
    reset_n = 1'b1;
    step(1);

    // JTAG address load (no RAM op) then write 0xDEADBEEF at 0x10
    jtag_strobe(K_A, 8'h10, 1'b0, 32'h0);
    check("addr_only_ready", bus.monitor_ready, 1);
    check("addr_only_addr", bus.dbg_jtag_addr, 8'h10);
    check("addr_only_no_we", bus.ram_we, 0);
    jtag_strobe(K_B, 8'h00, 1'b0, 32'hDEADBEEF);
    check("jwr_we", bus.ram_we, 1);
    check("jwr_addr", bus.ram_addr, 8'h10);
    check("jwr_wdata", bus.ram_wdata, 32'hDEADBEEF);
    check("jwr_be", bus.ram_be, 4'hF);
    check("jwr_busy", bus.monitor_ready, 0);
    step(1);
    check("jwr_done_ready", bus.monitor_ready, 1);
    check("jwr_addr_inc", bus.dbg_jtag_addr, 8'h11);
    check("jwr_we_off", bus.ram_we, 0);

    // JTAG read of 0x10 via ocimem_a with jdo[34]=1
    exp_q.push_back(32'hDEADBEEF);
    jtag_strobe(K_A, 8'h10, 1'b1, 32'h0);
    check("jrd_state1", bus.dbg_state, ST_J_RD);
    check("jrd_ram_addr", bus.ram_addr, 8'h10);
    step(1);
    check("jrd_state2", bus.dbg_state, ST_J_RDCAP);
    check("jrd_busy", bus.monitor_ready, 0);
    step(1);
    check_q("jrd_mondreg", bus.MonDReg);
    check("jrd_ready", bus.monitor_ready, 1);
    check("jrd_addr_inc", bus.dbg_jtag_addr, 8'h11);

    // Avalon write, debugaccess=1, be=0011
    av_start(1'b1, 8'h20, 32'h12345678, 4'b0011, 1'b1);
    check("awr_wait_g", bus.av_waitrequest, 1);
    step(1);
    check("awr_ack_g1", bus.av_waitrequest, 0);
    check("awr_we", bus.ram_we, 1);
    check("awr_be", bus.ram_be, 4'b0011);
    check("awr_addr", bus.ram_addr, 8'h20);
    check("awr_wdata", bus.ram_wdata, 32'h12345678);
    av_stop();
    step(1);
    check("awr_ack_one_cycle", bus.av_waitrequest, 1);
    check("awr_we_off", bus.ram_we, 0);

    // Avalon write without debugaccess: acked, no RAM write
    av_start(1'b1, 8'h21, 32'hCAFEF00D, 4'hF, 1'b0);
    step(1);
    check("awr_nodbg_ack", bus.av_waitrequest, 0);
    check("awr_nodbg_no_we", bus.ram_we, 0);
    av_stop();
    step(1);

    // Avalon reads: 0x20 holds only the low half-word, 0x21 untouched
    exp_q.push_back(32'h00005678);
    av_start(1'b0, 8'h20, 32'h0, 4'h0, 1'b0);
    step(1);
    check("ard_state", bus.dbg_state, ST_A_RD);
    check("ard_wait1", bus.av_waitrequest, 1);
    step(1);
    check("ard_wait2", bus.av_waitrequest, 1);
    step(1);
    check("ard_ack_g3", bus.av_waitrequest, 0);
    check_q("ard_data_be", bus.av_readdata);
    av_stop();
    step(1);
    check("ard_ack_one_cycle", bus.av_waitrequest, 1);
    exp_q.push_back(32'h0);
    av_start(1'b0, 8'h21, 32'h0, 4'h0, 1'b0);
    step(3);
    check("ard2_ack", bus.av_waitrequest, 0);
    check_q("ard2_nodbg_data", bus.av_readdata);
    av_stop();
    step(1);

    // Tie after reset: JTAG first
    apply_reset();
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h00005678);
    av_start(1'b0, 8'h20, 32'h0, 4'h0, 1'b0);
    jtag_strobe(K_A, 8'h10, 1'b1, 32'h0);
    check("tie1_jtag_first", bus.dbg_state, ST_J_RD);
    check("tie1_av_wait", bus.av_waitrequest, 1);
    step(2);
    check_q("tie1_mondreg", bus.MonDReg);
    check("tie1_idle", bus.dbg_state, ST_IDLE);
    step(3);
    check("tie1_av_ack", bus.av_waitrequest, 0);
    check_q("tie1_av_data", bus.av_readdata);
    av_stop();
    step(1);

    // Next tie: Avalon first, JTAG read waits
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h00005678);
    av_start(1'b0, 8'h10, 32'h0, 4'h0, 1'b0);
    jtag_strobe(K_A, 8'h20, 1'b1, 32'h0);
    check("tie2_av_first", bus.dbg_state, ST_A_RD);
    check("tie2_jtag_pending", bus.monitor_ready, 0);
    step(2);
    check("tie2_av_ack", bus.av_waitrequest, 0);
    check_q("tie2_av_data", bus.av_readdata);
    av_stop();
    step(4);
    check_q("tie2_mondreg", bus.MonDReg);
    check("tie2_ready", bus.monitor_ready, 1);
    check("tie2_addr", bus.dbg_jtag_addr, 8'h21);

    // Back-to-back strobes: second dropped, error sticky until ocimem_a
    jtag_strobe(K_B, 8'h00, 1'b0, 32'h11111111);
    jtag_strobe(K_B, 8'h00, 1'b0, 32'h22222222);
    check("err_set", bus.monitor_error, 1);
    check("err_ready", bus.monitor_ready, 1);
    check("err_addr_once", bus.dbg_jtag_addr, 8'h22);
    step(1);
    check("err_sticky", bus.monitor_error, 1);
    exp_q.push_back(32'h11111111);
    jtag_strobe(K_A, 8'h21, 1'b1, 32'h0);
    check("err_clear", bus.monitor_error, 0);
    step(2);
    check_q("err_first_wr", bus.MonDReg);
    exp_q.push_back(32'h0);
    jtag_strobe(K_NA, 8'h00, 1'b0, 32'h0);
    step(2);
    check_q("err_second_dropped", bus.MonDReg);
    check("na_addr_inc", bus.dbg_jtag_addr, 8'h23);

    // Address wrap
    jtag_strobe(K_A, 8'hFF, 1'b0, 32'h0);
    jtag_strobe(K_B, 8'h00, 1'b0, 32'hA5A5A5A5);
    check("wrap_wr_addr", bus.ram_addr, 8'hFF);
    step(1);
    check("wrap_after_wr", bus.dbg_jtag_addr, 8'h00);
    exp_q.push_back(32'hA5A5A5A5);
    jtag_strobe(K_A, 8'hFF, 1'b1, 32'h0);
    step(2);
    check_q("wrap_rd_data", bus.MonDReg);
    check("wrap_after_rd", bus.dbg_jtag_addr, 8'h00);

    // Reset during A_RD
    av_start(1'b0, 8'h10, 32'h0, 4'h0, 1'b0);
    step(1);
    check("mid_rst_in_ard", bus.dbg_state, ST_A_RD);
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", bus.dbg_state, ST_IDLE);
    check("mid_rst_wait", bus.av_waitrequest, 1);
    check("mid_rst_mondreg", bus.MonDReg, 0);
    check("mid_rst_readdata", bus.av_readdata, 0);
    check("mid_rst_jaddr", bus.dbg_jtag_addr, 0);
    check("mid_rst_ready", bus.monitor_ready, 1);
    step(3);
    check("mid_rst_wait_held", bus.av_waitrequest, 1);
    check("mid_rst_we", bus.ram_we, 0);
    av_stop();
    reset_n = 1'b1;
    step(2);
    check("post_rst_idle", bus.dbg_state, ST_IDLE);

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL exp_q_drain: %0d entries left, 0 required", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
